// File: rtl/jsilicon_pkg.sv
// Shared definitions for the parametrised calculator core: opcodes,
// controller state encoding and UART 8N1 frame constants.
package jsilicon_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;
    localparam int   FRAME_BITS = 10;

    // Number of bytes needed to carry a 2*width-bit result.
    function automatic int result_bytes(input int width);
        return (2 * width) / 8;
    endfunction

endpackage

// File: rtl/jsilicon_uart_tx.sv
// 8N1 UART transmitter. A new frame is loaded when idle, or directly on
// the last cycle of a stop bit so consecutive frames run without a gap.
module jsilicon_uart_tx
    import jsilicon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic                  active_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [BIT_W-1:0]      bit_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  tx_reg;

    logic bit_end;
    logic frame_end;
    logic load;

    assign bit_end   = active_reg && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign frame_end = bit_end && (bit_reg == BIT_W'(FRAME_BITS - 1));
    assign load      = tx_start && (!active_reg || frame_end);

    // Bit timer, bit counter and frame shifter; tx is driven straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '1;
            tx_reg     <= UART_STOP;
        end else if (load) begin
            active_reg <= 1'b1;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= {UART_STOP, tx_data, UART_START};
            tx_reg     <= UART_START;
        end else if (frame_end) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            tx_reg     <= UART_STOP;
        end else if (bit_end) begin
            cnt_reg    <= '0;
            bit_reg    <= bit_reg + 1'b1;
            shift_reg  <= {UART_STOP, shift_reg[FRAME_BITS-1:1]};
            tx_reg     <= shift_reg[1];
        end else if (active_reg) begin
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    assign tx      = tx_reg;
    assign tx_done = frame_end;

endmodule

// File: rtl/jsilicon_calc_core.sv
// Parametrised calculator core: one command per handshake, registered
// 2*WIDTH-bit result, divide-by-zero flag, result streamed LSB byte first
// over 8N1 UART.
module jsilicon_calc_core
    import jsilicon_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ena,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         opcode,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               err,
    output logic               busy,
    output logic               tx
);

    localparam int RES_W  = 2 * WIDTH;
    localparam int NBYTES = result_bytes(WIDTH);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SH_W   = $clog2(RES_W);

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;

    logic [RES_W-1:0] result_reg;
    logic             result_valid_reg;
    logic             err_reg;
    logic [RES_W-1:0] alu_result;
    logic             alu_err;

    logic [IDX_W-1:0] byte_idx_reg;
    logic [IDX_W-1:0] idx_sel;
    logic [7:0]       res_bytes [NBYTES];
    logic [7:0]       tx_data;

    logic accept;
    logic tx_start;
    logic tx_done;
    logic last_byte;

    // Ready is withheld during reset so the reset cycle never looks acceptable.
    assign cmd_ready = (state_reg == ST_IDLE) && ena && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign last_byte = (byte_idx_reg == IDX_W'(NBYTES - 1));

    // Controller state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and UART request; the request drops on the final frame's last cycle.
    always_comb begin
        state_next = state_reg;
        tx_start   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                tx_start = !(tx_done && last_byte);
                if (tx_done && last_byte) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture on the accepting edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= OP_ADD;
        end else if (accept) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= opcode;
        end
    end

    // Combinational ALU on zero-extended operands, all results mod 2^RES_W.
    always_comb begin
        logic [RES_W-1:0] a_ext;
        logic [RES_W-1:0] b_ext;
        a_ext      = {{WIDTH{1'b0}}, a_reg};
        b_ext      = {{WIDTH{1'b0}}, b_reg};
        alu_result = '0;
        alu_err    = 1'b0;
        case (op_reg)
            OP_ADD: alu_result = a_ext + b_ext;
            OP_SUB: alu_result = a_ext - b_ext;
            OP_MUL: alu_result = a_ext * b_ext;
            OP_AND: alu_result = a_ext & b_ext;
            OP_OR:  alu_result = a_ext | b_ext;
            OP_XOR: alu_result = a_ext ^ b_ext;
            OP_SHL: alu_result = a_ext << b_reg[SH_W-1:0];
            OP_DIV: begin
                if (b_reg == '0) begin
                    alu_result = '1;
                    alu_err    = 1'b1;
                end else begin
                    alu_result = a_ext / b_ext;
                end
            end
            default: alu_result = '0;
        endcase
    end

    // Result register stage: loaded once in EXEC, held until the next command.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            result_valid_reg <= (state_reg == ST_EXEC);
            if (state_reg == ST_EXEC) begin
                result_reg <= alu_result;
                err_reg    <= alu_err;
            end else if (accept) begin
                err_reg    <= 1'b0;
            end
        end
    end

    // Byte index walks 0..NBYTES-1, advancing on each completed frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx_reg <= '0;
        end else if (state_reg != ST_SEND) begin
            byte_idx_reg <= '0;
        end else if (tx_done) begin
            byte_idx_reg <= last_byte ? '0 : byte_idx_reg + 1'b1;
        end
    end

    // On a frame boundary the transmitter reloads immediately, so present the next byte.
    assign idx_sel = (tx_done && !last_byte) ? byte_idx_reg + 1'b1 : byte_idx_reg;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign res_bytes[gi] = result_reg[gi*8 +: 8];
    end

    assign tx_data = res_bytes[idx_sel];

    jsilicon_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clock    (clock),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_done  (tx_done)
    );

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign err          = err_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule
